win_check_sequencer: RTL and testbench

Sequences the win/draw evaluation after every accepted Connect-4 move. On a `start` pulse it walks outward from the last-placed piece through the board memory read port along four directions, counting same-player pieces. It reports a win when a count reaches four, and a draw when the board is full with no win. It sits between the top-level game controller, which issues `start` and consumes `done`/`gameOver`/`winner`, and the board RAM; it is the only reader of that RAM during a check.

---
 rtl/connect4_pkg.sv | 45 ++++
 rtl/win_check_sequencer_if.sv | 30 +++
 rtl/board_coord.sv | 24 ++
 rtl/win_check_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_win_check_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board size defaults, cell and winner
// encodings, win-check direction deltas and the sequencer state type.
package connect4_pkg;

  localparam int COLS_DEF = 7;
  localparam int ROWS_DEF = 6;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_P1    = 2'd1,
    CELL_P2    = 2'd2
  } cell_e;

  localparam logic [3:0] WIN_NONE = 4'd0;
  localparam logic [3:0] WIN_P1   = 4'd1;
  localparam logic [3:0] WIN_P2   = 4'd2;
  localparam logic [3:0] WIN_DRAW = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_COMPARE,
    S_RAY_END,
    S_DONE
  } state_e;

  // Direction deltas: d0 (1,0) horizontal, d1 (0,1) vertical,
  // d2 (1,1) diagonal, d3 (1,-1) anti-diagonal.
  function automatic logic signed [3:0] dir_dc(input logic [1:0] d);
    return (d == 2'd1) ? 4'sd0 : 4'sd1;
  endfunction

  function automatic logic signed [3:0] dir_dr(input logic [1:0] d);
    logic signed [3:0] r;
    case (d)
      2'd0:    r = 4'sd0;
      2'd1:    r = 4'sd1;
      2'd2:    r = 4'sd1;
      default: r = -4'sd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/win_check_sequencer_if.sv
// Signal bundle between the game controller / board RAM and the win-check
// sequencer.
//   start/move_col/move_row/player/new_game : controller requests
//   busy/done/gameOver/winner               : check status and result
//   rd_en/rd_addr/rd_data                   : board RAM read port
// slave  = sequencer view, master = controller + RAM view.
interface win_check_sequencer_if;
  logic       start;
  logic [2:0] move_col;
  logic [2:0] move_row;
  logic [1:0] player;
  logic       new_game;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic       busy;
  logic       done;
  logic       gameOver;
  logic [3:0] winner;

  modport slave (
    input  start, move_col, move_row, player, new_game, rd_data,
    output rd_en, rd_addr, busy, done, gameOver, winner
  );

  modport master (
    output start, move_col, move_row, player, new_game, rd_data,
    input  rd_en, rd_addr, busy, done, gameOver, winner
  );
endinterface

// File: rtl/board_coord.sv
// Combinational board coordinate check: maps a signed (col,row) to a
// bounds flag and the linear cell address row*COLS + col.
//   col_i/row_i  : signed 4-bit coordinates
//   in_bounds_o  : 1 when 0 <= col < COLS and 0 <= row < ROWS
//   addr_o       : cell address, meaningful only when in_bounds_o
module board_coord
  import connect4_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic signed [3:0] col_i,
  input  logic signed [3:0] row_i,
  output logic              in_bounds_o,
  output logic [5:0]        addr_o
);

  always_comb begin
    in_bounds_o = (col_i >= 4'sd0) && (row_i >= 4'sd0) &&
                  (int'(col_i) < COLS) && (int'(row_i) < ROWS);
    addr_o      = 6'(int'(row_i) * COLS + int'(col_i));
  end

endmodule

// File: rtl/win_check_sequencer.sv
// Win/draw evaluation after each accepted Connect-4 move. Walks outward
// from the placed piece in four directions (both signs) through the board
// RAM read port, counting same-player pieces; four in a line is a win, a
// full board without a win is a draw.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : controller request/result and board RAM read port
module win_check_sequencer
  import connect4_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input logic                   clk,
  input logic                   resetn,
  win_check_sequencer_if.slave  bus
);

  localparam logic [5:0] CELLS = 6'(ROWS * COLS);

  state_e     state_q, state_d;
  logic [1:0] d_q, d_d;
  logic       neg_q, neg_d;
  logic [2:0] k_q, k_d;
  logic [2:0] count_q, count_d;
  logic [2:0] col_q, col_d;
  logic [2:0] row_q, row_d;
  logic [1:0] player_q, player_d;
  logic [5:0] moves_q, moves_d;
  logic       game_over_q, game_over_d;
  logic [3:0] winner_q, winner_d;
  logic       rd_en_q, rd_en_d;
  logic [5:0] rd_addr_q, rd_addr_d;

  logic signed [3:0] ks, off_c, off_r, tgt_col, tgt_row;
  logic              tgt_in;
  logic [5:0]        tgt_addr;

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    neg_d       = neg_q;
    k_d         = k_q;
    count_d     = count_q;
    col_d       = col_q;
    row_d       = row_q;
    player_d    = player_q;
    moves_d     = moves_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !game_over_q) begin
          if (bus.player == CELL_P1 || bus.player == CELL_P2) begin
            col_d    = bus.move_col;
            row_d    = bus.move_row;
            player_d = bus.player;
            moves_d  = moves_q + 6'd1;
            state_d  = S_SETUP;
          end else begin
            // Invalid owner: acknowledge with done, leave result untouched.
            state_d = S_DONE;
          end
        end
      end
      S_SETUP: begin
        d_d     = 2'd0;
        neg_d   = 1'b0;
        k_d     = 3'd1;
        count_d = 3'd1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // rd_en_q already carries the bounds decision for this probe.
        state_d = rd_en_q ? S_COMPARE : S_RAY_END;
      end
      S_COMPARE: begin
        if (bus.rd_data == player_q) begin
          count_d = count_q + 3'd1;
          k_d     = k_q + 3'd1;
          if (count_q >= 3'd3) begin
            game_over_d = 1'b1;
            winner_d    = {2'b00, player_q};
            state_d     = S_DONE;
          end else if (k_q < 3'd3) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_RAY_END;
          end
        end else begin
          state_d = S_RAY_END;
        end
      end
      S_RAY_END: begin
        if (!neg_q) begin
          neg_d   = 1'b1;
          k_d     = 3'd1;
          state_d = S_ISSUE;
        end else if (d_q != 2'd3) begin
          d_d     = d_q + 2'd1;
          neg_d   = 1'b0;
          k_d     = 3'd1;
          count_d = 3'd1;
          state_d = S_ISSUE;
        end else begin
          if (moves_q == CELLS) begin
            game_over_d = 1'b1;
            winner_d    = WIN_DRAW;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.new_game) begin
      state_d     = S_IDLE;
      moves_d     = '0;
      game_over_d = 1'b0;
      winner_d    = WIN_NONE;
    end
  end

  // The probe address is computed from next-state values so the registered
  // rd_en/rd_addr are already valid during ISSUE and rd_data arrives in
  // COMPARE one cycle later.
  always_comb begin
    ks    = $signed({1'b0, k_d});
    off_c = dir_dc(d_d) * ks;
    off_r = dir_dr(d_d) * ks;
    if (neg_d) begin
      off_c = -off_c;
      off_r = -off_r;
    end
    tgt_col = $signed({1'b0, col_d}) + off_c;
    tgt_row = $signed({1'b0, row_d}) + off_r;
  end

  board_coord #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_coord (
    .col_i      (tgt_col),
    .row_i      (tgt_row),
    .in_bounds_o(tgt_in),
    .addr_o     (tgt_addr)
  );

  always_comb begin
    rd_en_d   = (state_d == S_ISSUE) && tgt_in;
    rd_addr_d = rd_en_d ? tgt_addr : rd_addr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      d_q         <= '0;
      neg_q       <= 1'b0;
      k_q         <= '0;
      count_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      player_q    <= '0;
      moves_q     <= '0;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      neg_q       <= neg_d;
      k_q         <= k_d;
      count_q     <= count_d;
      col_q       <= col_d;
      row_q       <= row_d;
      player_q    <= player_d;
      moves_q     <= moves_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.gameOver = game_over_q;
  assign bus.winner   = winner_q;

endmodule

// File: tb/tb_win_check_sequencer.sv
// Directed bench for win_check_sequencer with a behavioural board RAM.
module tb_win_check_sequencer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  win_check_sequencer_if bus();

  win_check_sequencer #(
    .COLS(7),
    .ROWS(6)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  logic [1:0] board [0:41];
  int n_assert = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int cyc;
  int dn;

  // Board RAM: one-cycle read latency.
  initial bus.rd_data = 2'd0;
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= board[bus.rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && bus.rd_en) begin
      rd_cnt++;
      chk("rd_addr_in_range", 32'(bus.rd_addr < 6'd42), 1);
    end
  end

  task automatic clear_board();
    for (int i = 0; i < 42; i++) board[i] = 2'd0;
  endtask

  task automatic set_cell(input int c, input int r, input logic [1:0] v);
    board[r * 7 + c] = v;
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (cyc = cycles after start).
  task automatic run_check(input logic [2:0] c, input logic [2:0] r, input logic [1:0] p, output int n);
    bus.start    = 1'b1;
    bus.move_col = c;
    bus.move_row = r;
    bus.player   = p;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    if (p == 2'd1 || p == 2'd2) chk("busy_after_start", 32'(bus.busy), 1);
    while (!bus.done && n < 70) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 32'(n <= 58), 1);
  endtask

  task automatic pulse_new_game();
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int k);
    k = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) k++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.move_col = '0; bus.move_row = '0;
    bus.player = '0; bus.new_game = 1'b0;
    resetn = 1'b0;
    clear_board();
    @(negedge clk); @(negedge clk);
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_gameOver", 32'(bus.gameOver), 0);
    chk("rst_winner", 32'(bus.winner), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Horizontal win, P1 row 0 cols 0-3, placed at col 3.
    for (int c = 0; c < 4; c++) set_cell(c, 0, 2'd1);
    run_check(3'd3, 3'd0, 2'd1, cyc);
    chk("horiz_cycles", cyc, 11);
    chk("horiz_gameOver", 32'(bus.gameOver), 1);
    chk("horiz_winner", 32'(bus.winner), 1);
    @(negedge clk);
    chk("horiz_done_pulse", 32'(bus.done), 0);
    chk("horiz_busy_after", 32'(bus.busy), 0);
    chk("horiz_winner_held", 32'(bus.winner), 1);
    pulse_new_game();
    chk("ng_gameOver", 32'(bus.gameOver), 0);
    chk("ng_winner", 32'(bus.winner), 0);

    // Vertical win, P2 col 6 rows 0-3, placed at row 3.
    clear_board();
    for (int r = 0; r < 4; r++) set_cell(6, r, 2'd2);
    run_check(3'd6, 3'd3, 2'd2, cyc);
    chk("vert_cycles", cyc, 16);
    chk("vert_gameOver", 32'(bus.gameOver), 1);
    chk("vert_winner", 32'(bus.winner), 2);
    @(negedge clk);
    pulse_new_game();

    // Anti-diagonal win, placed in the middle of the line.
    clear_board();
    set_cell(0, 3, 2'd1); set_cell(1, 2, 2'd1); set_cell(2, 1, 2'd1); set_cell(3, 0, 2'd1);
    run_check(3'd1, 3'd2, 2'd1, cyc);
    chk("adiag_cycles", cyc, 28);
    chk("adiag_gameOver", 32'(bus.gameOver), 1);
    chk("adiag_winner", 32'(bus.winner), 1);
    @(negedge clk);
    pulse_new_game();

    // Three in a row blocked by P2.
    clear_board();
    for (int c = 0; c < 3; c++) set_cell(c, 0, 2'd1);
    set_cell(3, 0, 2'd2);
    run_check(3'd2, 3'd0, 2'd1, cyc);
    chk("three_cycles", cyc, 26);
    chk("three_gameOver", 32'(bus.gameOver), 0);
    chk("three_winner", 32'(bus.winner), 0);
    @(negedge clk);
    chk("three_busy_after", 32'(bus.busy), 0);

    // Asynchronous reset in the middle of a check.
    bus.start = 1'b1; bus.move_col = 3'd2; bus.move_row = 3'd0; bus.player = 2'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", 32'(bus.busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_rd_en", 32'(bus.rd_en), 0);
    chk("midrst_rd_addr", 32'(bus.rd_addr), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Corner origin on an otherwise empty board: 3 in-bounds reads only.
    clear_board();
    set_cell(0, 0, 2'd1);
    rd_cnt = 0;
    run_check(3'd0, 3'd0, 2'd1, cyc);
    chk("corner_cycles", cyc, 21);
    chk("corner_reads", rd_cnt, 3);
    chk("corner_gameOver", 32'(bus.gameOver), 0);
    @(negedge clk);
    pulse_new_game();

    // Draw pattern: no four in any line.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        set_cell(c, r, ((((c >> 1) + r) & 1) != 0) ? 2'd2 : 2'd1);

    // Invalid owner: done at once, not counted.
    run_check(3'd2, 3'd2, 2'd0, cyc);
    chk("invalid_cycles", cyc, 1);
    chk("invalid_gameOver", 32'(bus.gameOver), 0);
    chk("invalid_winner", 32'(bus.winner), 0);
    @(negedge clk);

    // Abort with new_game 5 cycles after start.
    bus.start = 1'b1; bus.move_col = 3'd3; bus.move_row = 3'd3; bus.player = 2'd1;
    @(negedge clk);
    bus.start = 1'b0;
    dn = bus.done ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    count_done(70, cyc);
    chk("abort_no_done", dn + cyc, 0);

    // start and new_game together: start dropped.
    bus.start = 1'b1; bus.new_game = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.new_game = 1'b0;
    chk("simul_busy", 32'(bus.busy), 0);
    count_done(10, dn);
    chk("simul_no_done", dn, 0);

    // 42 accepted non-winning moves: only the last reports a draw.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        run_check(3'(c), 3'(r), board[r * 7 + c], cyc);
        chk($sformatf("draw_gameOver_%0d", r * 7 + c), 32'(bus.gameOver), (r * 7 + c == 41) ? 1 : 0);
        chk($sformatf("draw_winner_%0d", r * 7 + c), 32'(bus.winner), (r * 7 + c == 41) ? 3 : 0);
        @(negedge clk);
      end
    end

    // Start while gameOver is ignored.
    bus.start = 1'b1; bus.move_col = 3'd0; bus.move_row = 3'd0; bus.player = 2'd1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("over_busy", 32'(bus.busy), 0);
    count_done(10, dn);
    chk("over_no_done", dn, 0);
    chk("over_gameOver", 32'(bus.gameOver), 1);
    chk("over_winner", 32'(bus.winner), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
